// File: rtl/sw_pio_poller_pkg.sv
// Shared types and constants for the switch PIO poller.
package sw_pio_poller_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, EVAL} poll_state_t;
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
endpackage

// File: rtl/sw_debounce.sv
// Debounces polled switch samples: a new value is published after STABLE_COUNT identical samples.
module sw_debounce #(
  parameter int DATA_W       = 10,
  parameter int STABLE_COUNT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] sw_stable,
  output logic              sw_changed,
  output logic              accept
);
  localparam int CNT_W = $clog2(STABLE_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);

  logic [DATA_W-1:0] candidate, cand_nxt;
  logic [CNT_W-1:0]  stable_cnt, cnt_nxt;

  always_comb begin
    cand_nxt = candidate;
    cnt_nxt  = stable_cnt;
    accept   = 1'b0;
    if (sample_valid) begin
      if (sample != candidate) begin
        cand_nxt = sample;
        cnt_nxt  = CNT_W'(1);
      end else if (stable_cnt != CNT_MAX) begin
        cnt_nxt = stable_cnt + 1'b1;
      end
      // The count includes the current sample, so acceptance uses the next-state values.
      accept = (cnt_nxt == CNT_MAX) && (cand_nxt != sw_stable);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate  <= '0;
      stable_cnt <= '0;
      sw_stable  <= '0;
      sw_changed <= 1'b0;
    end else begin
      candidate  <= cand_nxt;
      stable_cnt <= cnt_nxt;
      sw_changed <= accept;
      if (accept) sw_stable <= cand_nxt;
    end
  end
endmodule

// File: rtl/sw_pio_poller.sv
// Avalon-MM read master that periodically polls the switch PIO and publishes a debounced word,
// a change pulse and a sticky interrupt; read accepted after waitrequest, data one cycle later.
module sw_pio_poller
  import sw_pio_poller_pkg::*;
#(
  parameter int POLL_CYCLES    = 50000,
  parameter int STABLE_COUNT   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int DATA_W         = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] sw_stable,
  output logic              sw_changed,
  output logic              irq,
  input  logic              irq_ack,
  output logic              rd_timeout
);
  localparam int TMR_W = $clog2(POLL_CYCLES);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  poll_state_t       state, state_nxt;
  logic [TMR_W-1:0]  poll_timer;
  logic              poll_tick;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [DATA_W-1:0] sample;
  logic              capture, timeout, accept;
  logic              unused_readdata;

  assign unused_readdata = ^avm_readdata[31:DATA_W];
  assign avm_address     = PIO_DATA_ADDR;
  assign poll_tick       = enable && (poll_timer == '0);

  // Timer sits at its reload value while disabled, so the first tick comes POLL_CYCLES after enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            poll_timer <= TMR_RELOAD;
    else if (!enable || poll_timer == '0)    poll_timer <= TMR_RELOAD;
    else                                     poll_timer <= poll_timer - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    avm_read  = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: if (poll_tick) state_nxt = REQ;
      REQ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) state_nxt = WAIT;
      end
      WAIT: begin
        if (avm_readdatavalid) begin
          capture   = 1'b1;
          state_nxt = EVAL;
        end else if (tmo_cnt == TMO_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      EVAL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      sample     <= '0;
      rd_timeout <= 1'b0;
      irq        <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_timeout <= timeout;
      if (state == REQ)       tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      if (capture) sample <= avm_readdata[DATA_W-1:0];
      // A new change outranks a simultaneous acknowledge.
      if (accept)       irq <= 1'b1;
      else if (irq_ack) irq <= 1'b0;
    end
  end

  sw_debounce #(
    .DATA_W       (DATA_W),
    .STABLE_COUNT (STABLE_COUNT)
  ) u_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (state == EVAL),
    .sample       (sample),
    .sw_stable    (sw_stable),
    .sw_changed   (sw_changed),
    .accept       (accept)
  );
endmodule

// File: tb/tb_sw_pio_poller.sv
// Self-checking bench for sw_pio_poller: scripted scenarios plus randomized polls against a sample-history model.
module tb_sw_pio_poller;
  localparam int POLL_CYCLES    = 8;
  localparam int STABLE_COUNT   = 3;
  localparam int TIMEOUT_CYCLES = 4;
  localparam int DATA_W         = 10;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic [1:0]        avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic [DATA_W-1:0] sw_stable;
  logic              sw_changed;
  logic              irq;
  logic              irq_ack;
  logic              rd_timeout;

  sw_pio_poller #(
    .POLL_CYCLES    (POLL_CYCLES),
    .STABLE_COUNT   (STABLE_COUNT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .DATA_W         (DATA_W)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .sw_stable         (sw_stable),
    .sw_changed        (sw_changed),
    .irq               (irq),
    .irq_ack           (irq_ack),
    .rd_timeout        (rd_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] m_stable = '0;
  logic              m_irq    = 1'b0;
  logic [DATA_W-1:0] hist[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Value accepted once the trailing run of identical evaluated samples reaches STABLE_COUNT.
  function automatic bit model_eval(input logic [DATA_W-1:0] s);
    int run;
    run = 0;
    hist.push_back(s);
    for (int i = hist.size() - 1; i >= 0 && hist[i] == s; i--) run++;
    if (run >= STABLE_COUNT && s != m_stable) begin
      m_stable = s;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic wait_read(output int cyc);
    cyc = 0;
    while (!avm_read && cyc < 4 * POLL_CYCLES) begin
      step();
      cyc++;
    end
    chk("read_launch", 32'(avm_read), 32'd1);
  endtask

  task automatic poll(input logic [31:0] data, input int ws, input bit withhold,
                      input bit ack_on_eval, input bit drop_en);
    int c;
    bit chg;
    wait_read(c);
    if (drop_en) enable = 1'b0;
    for (int i = 0; i < ws; i++) begin
      avm_waitrequest = 1'b1;
      step();
      chk("req_hold_read", 32'(avm_read), 32'd1);
      chk("req_hold_addr", 32'(avm_address), 32'd0);
    end
    avm_waitrequest = 1'b0;
    step();
    chk("single_accept", 32'(avm_read), 32'd0);
    if (!withhold) begin
      avm_readdata      = data;
      avm_readdatavalid = 1'b1;
      step();
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      chg = model_eval(data[DATA_W-1:0]);
      if (chg)              m_irq = 1'b1;
      else if (ack_on_eval) m_irq = 1'b0;
      irq_ack = ack_on_eval;
      step();
      irq_ack = 1'b0;
      chk("sw_stable", 32'(sw_stable), 32'(m_stable));
      chk("sw_changed", 32'(sw_changed), 32'(chg));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("no_timeout", 32'(rd_timeout), 32'd0);
      step();
      chk("changed_pulse_end", 32'(sw_changed), 32'd0);
    end else begin
      for (int i = 1; i <= TIMEOUT_CYCLES; i++) begin
        step();
        chk("rd_timeout", 32'(rd_timeout), 32'(i == TIMEOUT_CYCLES));
      end
      avm_readdata      = {22'h0, ~m_stable};
      avm_readdatavalid = 1'b1;
      step();
      avm_readdatavalid = 1'b0;
      chk("late_rdv_stable", 32'(sw_stable), 32'(m_stable));
      chk("late_rdv_changed", 32'(sw_changed), 32'd0);
      chk("timeout_pulse_end", 32'(rd_timeout), 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_read"}, 32'(avm_read), 32'd0);
    chk({tag, "_stable"}, 32'(sw_stable), 32'd0);
    chk({tag, "_changed"}, 32'(sw_changed), 32'd0);
    chk({tag, "_irq"}, 32'(irq), 32'd0);
    chk({tag, "_timeout"}, 32'(rd_timeout), 32'd0);
  endtask

  initial begin
    int c;
    bit seen;
    logic [DATA_W-1:0] pick, prev;
    logic [DATA_W-1:0] pool [4];
    pool[0] = 10'h000; pool[1] = 10'h3FF; pool[2] = 10'h155; pool[3] = 10'h2AA;

    reset_n = 1'b0; enable = 1'b0; avm_waitrequest = 1'b0;
    avm_readdata = '0; avm_readdatavalid = 1'b0; irq_ack = 1'b0;
    step(); step();
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    step();

    // First launch timing and an all-zero slave
    enable = 1'b1;
    c = 0;
    while (!avm_read && c < 50) begin
      step();
      c++;
    end
    chk("first_read_cycle", 32'(c), 32'd8);
    repeat (4) poll(32'h0, 0, 0, 0, 0);

    // Upper readdata bits ignored; change then irq set-wins-over-ack; then ack clears
    repeat (3) poll(32'hFFFF_FEA5, 0, 0, 0, 0);
    poll(32'h155, 0, 0, 0, 0);
    poll(32'h155, 1, 0, 0, 0);
    poll(32'h155, 0, 0, 1, 0);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    m_irq = 1'b0;
    chk("irq_ack_clear", 32'(irq), 32'd0);

    // Bouncing input: only the final run of three is accepted
    poll(32'h001, 0, 0, 0, 0);
    poll(32'h000, 0, 0, 0, 0);
    poll(32'h001, 0, 0, 0, 0);
    poll(32'h001, 0, 0, 0, 0);
    poll(32'h001, 0, 0, 0, 0);

    // Long waitrequest stall
    poll(32'h3C0, 5, 0, 0, 0);
    poll(32'h3C0, 5, 0, 0, 0);
    poll(32'h3C0, 2, 0, 0, 0);

    // Timeout in the middle of a run leaves the debounce state alone
    poll(32'h0AA, 0, 0, 0, 0);
    poll(32'h0AA, 0, 0, 0, 0);
    poll(32'h0, 1, 1, 0, 0);
    poll(32'h0AA, 0, 0, 0, 0);

    // Enable dropped during REQ: read completes, then no further reads
    poll(32'h0AA, 2, 0, 0, 1);
    seen = 1'b0;
    repeat (4 * POLL_CYCLES) begin
      step();
      if (avm_read) seen = 1'b1;
    end
    chk("no_read_when_disabled", 32'(seen), 32'd0);
    enable = 1'b1;

    // Asynchronous reset while waiting for read data
    wait_read(c);
    avm_waitrequest = 1'b0;
    step();
    chk("pre_reset_stable", 32'(sw_stable), 32'(m_stable));
    chk("pre_reset_irq", 32'(irq), 32'(m_irq));
    #2 reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    hist.delete();
    m_stable = '0;
    m_irq    = 1'b0;
    step();
    reset_n = 1'b1;

    // Randomized polls
    prev = pool[0];
    repeat (40) begin
      pick = ($urandom_range(0, 3) != 0) ? prev : pool[$urandom_range(0, 3)];
      prev = pick;
      poll({$urandom_range(0, 32'h3F_FFFF), pick}, $urandom_range(0, 3),
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
